input_debounce: RTL and testbench
=================================

// Module: input_debounce
// PURPOSE
//  Conditions the raw asynchronous serial input bit before the 4-state Moore sequence FSM consumes it as x.
//  Synchronises the input, rejects glitches shorter than DEBOUNCE_CYCLES and drives a clean level x_clean.
//  Also drives one-cycle rise/fall strobes, so the FSM sees exactly one settled transition per real input change.
// PARAMETERS
//  SYNC_STAGES      2  synchroniser flops on x_raw; legal range >= 2
//  DEBOUNCE_CYCLES  4  consecutive equal synchronised samples required to accept a new level; legal range >= 2
//  CNT_W            $clog2(DEBOUNCE_CYCLES)+1  debounce counter width; derived, do not override
// PORTS
//  clk      in   1  single clock; all state updates on rising edge
//  rst      in   1  reset, synchronous, active-high
//  x_raw    in   1  asynchronous raw input (switch/pin)
//  x_clean  out  1  debounced level; feeds the FSM x input
//  x_rise   out  1  one-cycle pulse when x_clean goes 0->1
//  x_fall   out  1  one-cycle pulse when x_clean goes 1->0
//  busy     out  1  1 while a candidate level change is being qualified (CHK_HI/CHK_LO)
// BEHAVIOUR
//  - Reset (rst=1 at a rising edge):
//    - sync chain=0, state=STABLE_LO, cnt=0;
//    - x_clean=0, x_rise=0, x_fall=0, busy=0, all registered.
//  - s = last synchroniser flop output; the FSM acts on s only, never on x_raw.
//  - States (2-bit encoding): STABLE_LO=00, CHK_HI=01, STABLE_HI=10, CHK_LO=11.
//  - STABLE_LO:
//    - s=1 -> CHK_HI, cnt<=1.
//    - else hold, cnt<=0.
//  - CHK_HI:
//    - s=0 -> STABLE_LO, cnt<=0 (glitch rejected, no output change).
//    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, x_clean<=1, x_rise<=1, cnt<=0.
//    - else cnt<=cnt+1.
//  - STABLE_HI / CHK_LO: mirror image with s polarity inverted; acceptance sets x_clean<=0, x_fall<=1.
//  - x_rise/x_fall:
//    - high for exactly one cycle, the cycle in which x_clean first shows its new value.
//    - never both high; otherwise 0.
//  - busy = (state==CHK_HI || state==CHK_LO), registered with the state.
//  - Latency: x_clean changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting as edge 1 the first edge that samples the new x_raw level.
//    - Applies only when x_raw is held stable through that edge.
//    - Default: 6 edges.
//  - Glitch: a level on s lasting < DEBOUNCE_CYCLES samples produces no change on x_clean, x_rise or x_fall.
//  - Counter: unsigned, never wraps; it is reset on every state change, so max value is DEBOUNCE_CYCLES-1.
//  - Illegal/unreachable state: recovers to STABLE_LO with outputs 0 on the next edge.
//  - Reset mid-qualification discards the candidate; no strobe is emitted.
// STRUCTURE
//  - Shared package (seq_pkg):
//    - deb_state_t enum holding the four state encodings.
//    - Default SYNC_STAGES and DEBOUNCE_CYCLES localparams.
//  - Sub-module bit_sync:
//    - parameterised SYNC_STAGES flop chain with synchronous reset to 0.
//    - Instantiated once on x_raw.
//  - Top holds the next-state/count logic and the registered outputs only.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1. Assert rst 3 cycles with x_raw=1 -> x_clean=0, x_rise=0, x_fall=0, busy=0 throughout reset.
//  2. After reset, drive x_raw 0->1 and hold -> x_clean=1 at edge 6, x_rise=1 for that cycle only, busy=1 during edges 3-5.
//  3. From STABLE_LO, pulse x_raw=1 for 3 cycles -> x_clean stays 0, no x_rise, busy returns to 0.
//  4. From STABLE_HI, drive x_raw=0 held -> x_clean=0 at edge 6, x_fall=1 for one cycle, x_rise stays 0.
//  5. Drive x_raw 1 for 2 cycles, 0 for 1 cycle, then 1 held -> qualification restarts; x_clean=1 at edge 6 counted from the final 0->1.
//  6. Assert rst while in CHK_HI with cnt=2 -> state STABLE_LO, x_clean=0, no x_rise on any cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the input conditioning ahead of the sequence FSM.
package seq_pkg;

  localparam int unsigned SyncStagesDefault     = 2;
  localparam int unsigned DebounceCyclesDefault = 4;

  typedef enum logic [1:0] {
    StStableLo = 2'b00,
    StChkHi    = 2'b01,
    StStableHi = 2'b10,
    StChkLo    = 2'b11
  } deb_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, synchronously cleared to 0.
module bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronises and debounces x_raw into a clean level plus one-cycle rise/fall strobes.
module input_debounce
  import seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SyncStagesDefault,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic x_raw,
  output logic x_clean,
  output logic x_rise,
  output logic x_fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic       s;
  deb_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic x_clean_q, x_clean_d;
  logic x_rise_q, x_rise_d;
  logic x_fall_q, x_fall_d;
  logic busy_q, busy_d;

  bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bit_sync (
    .clk (clk),
    .rst (rst),
    .d_i (x_raw),
    .q_o (s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_clean_d = x_clean_q;
    x_rise_d  = 1'b0;
    x_fall_d  = 1'b0;

    case (state_q)
      StStableLo: begin
        if (s) begin
          state_d = StChkHi;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StChkHi: begin
        if (!s) begin
          // Candidate died before qualifying: drop it silently.
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = StStableHi;
          cnt_d     = '0;
          x_clean_d = 1'b1;
          x_rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStableHi: begin
        if (!s) begin
          state_d = StChkLo;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StChkLo: begin
        if (s) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = StStableLo;
          cnt_d     = '0;
          x_clean_d = 1'b0;
          x_fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d   = StStableLo;
        cnt_d     = '0;
        x_clean_d = 1'b0;
      end
    endcase

    busy_d = (state_d == StChkHi) || (state_d == StChkLo);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StStableLo;
      cnt_q     <= '0;
      x_clean_q <= 1'b0;
      x_rise_q  <= 1'b0;
      x_fall_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_clean_q <= x_clean_d;
      x_rise_q  <= x_rise_d;
      x_fall_q  <= x_fall_d;
      busy_q    <= busy_d;
    end
  end

  assign x_clean = x_clean_q;
  assign x_rise  = x_rise_q;
  assign x_fall  = x_fall_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench: each step queues the expected {x_clean,x_rise,x_fall,busy} after the next edge.
module tb_input_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x_raw = 1'b1;
  logic x_clean, x_rise, x_fall, busy;

  typedef struct {
    int         idx;
    logic [3:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  step_cnt = 0;
  int  pass_cnt = 0;
  int  total_cnt = 0;

  always #5 clk = ~clk;

  input_debounce #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .x_raw   (x_raw),
    .x_clean (x_clean),
    .x_rise  (x_rise),
    .x_fall  (x_fall),
    .busy    (busy)
  );

  // Monitor: compares the outputs just after each edge against the queued expectation.
  always begin
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      total_cnt++;
      if ({x_clean, x_rise, x_fall, busy} === e.exp) begin
        pass_cnt++;
      end else begin
        $display("FAIL step%0d {clean,rise,fall,busy}: got %b expected %b",
                 e.idx, {x_clean, x_rise, x_fall, busy}, e.exp);
      end
    end
  end

  task automatic step(input logic r, input logic x, input logic [3:0] exp);
    sb_t e;
    @(negedge clk);
    rst   = r;
    x_raw = x;
    e.idx = step_cnt;
    e.exp = exp;
    sb_q.push_back(e);
    step_cnt++;
  endtask

  // Drop from STABLE_HI back to STABLE_LO with x_raw held low.
  task automatic go_low();
    step(0, 0, 4'b1000);
    step(0, 0, 4'b1000);
    step(0, 0, 4'b1001);
    step(0, 0, 4'b1001);
    step(0, 0, 4'b1001);
    step(0, 0, 4'b0010);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);
  endtask

  initial begin
    // 1: reset with x_raw high
    step(1, 1, 4'b0000);
    step(1, 1, 4'b0000);
    step(1, 1, 4'b0000);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);

    // 2: clean rise, accepted on edge 6
    step(0, 1, 4'b0000);
    step(0, 1, 4'b0000);
    step(0, 1, 4'b0001);
    step(0, 1, 4'b0001);
    step(0, 1, 4'b0001);
    step(0, 1, 4'b1100);
    step(0, 1, 4'b1000);
    step(0, 1, 4'b1000);

    // 4: clean fall from STABLE_HI
    go_low();

    // 3: three-cycle glitch is rejected
    step(0, 1, 4'b0000);
    step(0, 1, 4'b0000);
    step(0, 1, 4'b0001);
    step(0, 0, 4'b0001);
    step(0, 0, 4'b0001);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);

    // 5: 1,1,0 then 1 held restarts qualification
    step(0, 1, 4'b0000);
    step(0, 1, 4'b0000);
    step(0, 0, 4'b0001);
    step(0, 1, 4'b0001);
    step(0, 1, 4'b0000);
    step(0, 1, 4'b0001);
    step(0, 1, 4'b0001);
    step(0, 1, 4'b0001);
    step(0, 1, 4'b1100);
    step(0, 1, 4'b1000);
    go_low();

    // 6: reset in CHK_HI with cnt=2 discards the candidate
    step(0, 1, 4'b0000);
    step(0, 1, 4'b0000);
    step(0, 1, 4'b0001);
    step(0, 1, 4'b0001);
    step(1, 1, 4'b0000);
    step(1, 1, 4'b0000);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
    end
    total_cnt++;
    if (sb_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
